// File: rtl/fp_accum_pkg.sv
// Shared types and field positions for the FP32 accumulation controller.
package fp_accum_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exponent-field test; zero and denormal operands share exponent 0.
  function automatic logic is_zero_exp(input logic [EXP_MSB-EXP_LSB:0] exp_field);
    return (exp_field == '0);
  endfunction

endpackage

// File: rtl/fp_accum_ctrl.sv
// Sequences an external combinational FP32 adder to accumulate NUM_TERMS terms into one sum.
// Optional build macro FP_ACCUM_RELU_EN: clamp negative sums to zero on the sum_data output.
//
// state | meaning
// IDLE  | waiting for start; no terms accepted
// ACCUM | accepting terms, one per handshake
// DONE  | sum held on sum_valid/sum_data until sum_ready
module fp_accum_ctrl
  import fp_accum_pkg::*;
#(
  parameter int NUM_TERMS = 784,
  parameter int CNT_W     = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [FP_W-1:0] in_data,
  output logic            in_ready,
  output logic [FP_W-1:0] add_a,
  output logic [FP_W-1:0] add_b,
  input  logic [FP_W-1:0] add_y,
  output logic            sum_valid,
  output logic [FP_W-1:0] sum_data,
  input  logic            sum_ready,
  output logic            busy
);

  state_t            state, state_nxt;
  logic [FP_W-1:0]   acc, acc_nxt, sum_load;
  logic [CNT_W-1:0]  cnt;
  logic              hs, last;

  assign add_a = acc;
  assign add_b = in_data;
  assign hs    = in_valid & in_ready;
  assign last  = (cnt == CNT_W'(NUM_TERMS - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs && last) state_nxt = DONE;
      end
      DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
        if (sum_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The adder's implicit leading 1 is wrong for exponent 0, so bypass it on either side.
  always_comb begin
    acc_nxt = add_y;
    if (is_zero_exp(in_data[EXP_MSB:EXP_LSB])) begin
      acc_nxt = acc;
    end else if (is_zero_exp(acc[EXP_MSB:EXP_LSB])) begin
      acc_nxt = in_data;
    end
  end

`ifdef FP_ACCUM_RELU_EN
  assign sum_load = acc_nxt[FP_W-1] ? FP_ZERO : acc_nxt;
`else
  assign sum_load = acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= FP_ZERO;
      cnt      <= '0;
      sum_data <= FP_ZERO;
    end else if (state == IDLE) begin
      if (start) begin
        acc <= FP_ZERO;
        cnt <= '0;
      end
    end else if (hs) begin
      acc <= acc_nxt;
      if (last) begin
        cnt      <= '0;
        sum_data <= sum_load;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
